// File: rtl/render_cmd_master_if.sv
// Draw-command port and Avalon-MM master bundle for render_cmd_master.
// The master modport is the command master's view; the slave modport is the view of the source and render side.
interface render_cmd_master_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [6:0]  cmd_texture;
   logic [8:0]  cmd_x;
   logic [7:0]  cmd_y;
   logic        cmd_fill;
   logic [3:0]  master_address;
   logic        master_write;
   logic [31:0] master_writedata;
   logic        master_read;
   logic [31:0] master_readdata;
   logic        master_waitrequest;

   modport master (
      input  cmd_valid, cmd_texture, cmd_x, cmd_y, cmd_fill,
      output cmd_ready,
      output master_address, master_write, master_writedata, master_read,
      input  master_readdata, master_waitrequest
   );

   modport slave (
      output cmd_valid, cmd_texture, cmd_x, cmd_y, cmd_fill,
      input  cmd_ready,
      input  master_address, master_write, master_writedata, master_read,
      output master_readdata, master_waitrequest
   );
endinterface

// File: rtl/render_cmd_master.sv
// Buffers draw commands and expands each one into the render slave register
// write sequence (texture, x, y, plot), optionally polling status until idle.
module render_cmd_master #(
   parameter int FIFO_DEPTH = 4,
   parameter bit POLL_BUSY  = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   render_cmd_master_if.master  bus,
   output logic                 busy,
   output logic [15:0]          cmds_done
);

   localparam int AW = $clog2(FIFO_DEPTH);

   localparam logic [3:0] ADDR_STATUS = 4'd0;
   localparam logic [3:0] ADDR_X      = 4'd1;
   localparam logic [3:0] ADDR_Y      = 4'd2;
   localparam logic [3:0] ADDR_TEX    = 4'd4;
   localparam logic [3:0] ADDR_PLOT   = 4'd6;

   typedef struct packed {
      logic [6:0] texture;
      logic [8:0] x;
      logic [7:0] y;
      logic       fill;
   } cmd_t;

   typedef enum logic [2:0] {
      IDLE, WR_TEX, WR_X, WR_Y, WR_PLOT, POLL, DONE
   } state_t;

   cmd_t          fifo_mem [FIFO_DEPTH];
   logic [AW:0]   wr_ptr, rd_ptr;
   logic          fifo_empty, fifo_full;
   logic          push, pop;
   cmd_t          head, cur;

   state_t        state_q, state_d;
   logic          write_d, read_d;
   logic [3:0]    addr_d;
   logic [31:0]   data_d;
   logic          xfer_done;
   logic          tex_load, count_inc;
   logic [6:0]    last_tex;
   logic          tex_valid;
   logic          unused_readdata;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign bus.cmd_ready = !fifo_full;
   assign push = bus.cmd_valid && !fifo_full;
   assign head = fifo_mem[rd_ptr[AW-1:0]];

   assign busy      = !fifo_empty || (state_q != IDLE);
   assign xfer_done = (bus.master_write || bus.master_read) && !bus.master_waitrequest;
   assign unused_readdata = ^bus.master_readdata[31:1];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // NOTE: the storage array has no reset; the pointers alone define which
   // entries are valid, so it can map onto plain RAM/registers without a reset net.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr[AW-1:0]] <= '{texture: bus.cmd_texture, x: bus.cmd_x,
                                       y: bus.cmd_y, fill: bus.cmd_fill};
      end
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      write_d   = bus.master_write;
      read_d    = bus.master_read;
      addr_d    = bus.master_address;
      data_d    = bus.master_writedata;
      pop       = 1'b0;
      tex_load  = 1'b0;
      count_inc = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop = 1'b1;
               if (tex_valid && (head.texture == last_tex))
                  state_d = head.fill ? WR_PLOT : WR_X;
               else
                  state_d = WR_TEX;
            end
         end
         WR_TEX: begin
            if (xfer_done) begin
               write_d  = 1'b0;
               tex_load = 1'b1;
               state_d  = cur.fill ? WR_PLOT : WR_X;
            end else begin
               write_d = 1'b1;
               addr_d  = ADDR_TEX;
               data_d  = {25'b0, cur.texture};
            end
         end
         WR_X: begin
            if (xfer_done) begin
               write_d = 1'b0;
               state_d = WR_Y;
            end else begin
               write_d = 1'b1;
               addr_d  = ADDR_X;
               data_d  = {23'b0, cur.x};
            end
         end
         WR_Y: begin
            if (xfer_done) begin
               write_d = 1'b0;
               state_d = WR_PLOT;
            end else begin
               write_d = 1'b1;
               addr_d  = ADDR_Y;
               data_d  = {24'b0, cur.y};
            end
         end
         WR_PLOT: begin
            if (xfer_done) begin
               write_d = 1'b0;
               state_d = POLL_BUSY ? POLL : DONE;
            end else begin
               write_d = 1'b1;
               addr_d  = ADDR_PLOT;
               data_d  = 32'd0;
            end
         end
         POLL: begin
            // A busy reply drops the read for one cycle, then the else branch reissues it.
            if (xfer_done) begin
               read_d = 1'b0;
               if (!bus.master_readdata[0]) state_d = DONE;
            end else begin
               read_d = 1'b1;
               addr_d = ADDR_STATUS;
            end
         end
         DONE: begin
            count_inc = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q              <= IDLE;
         bus.master_write     <= 1'b0;
         bus.master_read      <= 1'b0;
         bus.master_address   <= 4'd0;
         bus.master_writedata <= 32'd0;
         cur                  <= '0;
         last_tex             <= 7'd0;
         tex_valid            <= 1'b0;
         cmds_done            <= 16'd0;
      end else begin
         state_q              <= state_d;
         bus.master_write     <= write_d;
         bus.master_read      <= read_d;
         bus.master_address   <= addr_d;
         bus.master_writedata <= data_d;
         if (pop) cur <= head;
         if (tex_load) begin
            last_tex  <= cur.texture;
            tex_valid <= 1'b1;
         end
         if (count_inc) cmds_done <= cmds_done + 16'd1;
      end
   end

   a_one_strobe: assert property (@(posedge clk) disable iff (rst)
      !(bus.master_write && bus.master_read));

   a_write_hold: assert property (@(posedge clk) disable iff (rst)
      (bus.master_write && bus.master_waitrequest) |=>
      (bus.master_write && $stable(bus.master_address) && $stable(bus.master_writedata)));

endmodule

// File: tb/tb_render_cmd_master.sv
// Scoreboard bench for render_cmd_master: one instance without status polling,
// one with polling; expected bus writes are queued when each command is accepted.
module tb_render_cmd_master;

   typedef struct {
      logic [3:0]  addr;
      logic [31:0] data;
   } xfer_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   render_cmd_master_if bus0 ();
   render_cmd_master_if bus1 ();

   logic        busy0, busy1;
   logic [15:0] done0, done1;

   render_cmd_master #(.FIFO_DEPTH(4), .POLL_BUSY(1'b0)) dut0 (
      .clk(clk), .rst(rst), .bus(bus0), .busy(busy0), .cmds_done(done0));

   render_cmd_master #(.FIFO_DEPTH(4), .POLL_BUSY(1'b1)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1), .busy(busy1), .cmds_done(done1));

   always #5 clk = ~clk;

   int    n_checks = 0;
   int    n_fail   = 0;
   int    cyc      = 0;
   int    poll_cnt = 0;
   int    t_tex0   = 0;
   int    t_plot0  = 0;
   int    t_rd1    = -1;
   xfer_t q0[$];
   xfer_t q1[$];
   logic [6:0] m_last_tex [2];
   bit         m_tex_valid [2];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Status reads report busy for the first three polls, idle afterwards.
   assign bus1.master_readdata   = {31'b0, (poll_cnt < 3)};
   assign bus1.master_waitrequest = 1'b0;
   assign bus0.master_readdata   = 32'd0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus1.master_read && !bus1.master_waitrequest) poll_cnt <= poll_cnt + 1;
   end

   always @(negedge clk) begin
      #1;
      if (!rst && bus0.master_write && !bus0.master_waitrequest) begin
         if (q0.size() == 0) begin
            check("dut0_unexpected_write", {28'b0, bus0.master_address}, 32'hFFFF_FFFF);
         end else begin
            xfer_t e;
            e = q0.pop_front();
            check("dut0_addr", {28'b0, bus0.master_address}, {28'b0, e.addr});
            check("dut0_data", bus0.master_writedata, e.data);
         end
         if (bus0.master_address == 4'd4) t_tex0 = cyc;
         if (bus0.master_address == 4'd6) t_plot0 = cyc;
      end
   end

   always @(negedge clk) begin
      #1;
      if (!rst && bus1.master_write && !bus1.master_waitrequest) begin
         if (q1.size() == 0) begin
            check("dut1_unexpected_write", {28'b0, bus1.master_address}, 32'hFFFF_FFFF);
         end else begin
            xfer_t e;
            e = q1.pop_front();
            check("dut1_addr", {28'b0, bus1.master_address}, {28'b0, e.addr});
            check("dut1_data", bus1.master_writedata, e.data);
         end
      end
      if (!rst && bus1.master_read && !bus1.master_waitrequest) begin
         check("dut1_read_addr", {28'b0, bus1.master_address}, 32'd0);
         if (t_rd1 >= 0) check("dut1_read_gap", cyc - t_rd1, 2);
         t_rd1 = cyc;
      end
   end

   task automatic push_cmd(input int sel, input logic [6:0] tex, input logic [8:0] x,
                           input logic [7:0] y, input logic fill);
      xfer_t e[$];
      int    n;
      if (sel == 0) begin
         bus0.cmd_valid = 1'b1; bus0.cmd_texture = tex; bus0.cmd_x = x;
         bus0.cmd_y = y; bus0.cmd_fill = fill;
      end else begin
         bus1.cmd_valid = 1'b1; bus1.cmd_texture = tex; bus1.cmd_x = x;
         bus1.cmd_y = y; bus1.cmd_fill = fill;
      end
      n = 0;
      while (((sel == 0) ? bus0.cmd_ready : bus1.cmd_ready) !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("push_ready", (sel == 0) ? bus0.cmd_ready : bus1.cmd_ready, 1);
      @(posedge clk);
      if (!(m_tex_valid[sel] && m_last_tex[sel] == tex))
         e.push_back('{addr: 4'd4, data: {25'b0, tex}});
      m_last_tex[sel]  = tex;
      m_tex_valid[sel] = 1'b1;
      if (!fill) begin
         e.push_back('{addr: 4'd1, data: {23'b0, x}});
         e.push_back('{addr: 4'd2, data: {24'b0, y}});
      end
      e.push_back('{addr: 4'd6, data: 32'd0});
      foreach (e[i]) begin
         if (sel == 0) q0.push_back(e[i]);
         else          q1.push_back(e[i]);
      end
      #1;
      if (sel == 0) bus0.cmd_valid = 1'b0;
      else          bus1.cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input int sel, input string tag);
      int n;
      n = 0;
      @(negedge clk);
      while (((sel == 0) ? busy0 : busy1) !== 1'b0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check(tag, (sel == 0) ? busy0 : busy1, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bus0.cmd_valid = 1'b0; bus0.cmd_texture = '0; bus0.cmd_x = '0;
      bus0.cmd_y = '0; bus0.cmd_fill = 1'b0; bus0.master_waitrequest = 1'b0;
      bus1.cmd_valid = 1'b0; bus1.cmd_texture = '0; bus1.cmd_x = '0;
      bus1.cmd_y = '0; bus1.cmd_fill = 1'b0;
      m_tex_valid[0] = 1'b0; m_tex_valid[1] = 1'b0;
      m_last_tex[0] = '0;    m_last_tex[1] = '0;

      repeat (3) @(negedge clk);
      check("rst_cmd_ready",  bus0.cmd_ready, 1);
      check("rst_write",      bus0.master_write, 0);
      check("rst_read",       bus0.master_read, 0);
      check("rst_address",    {28'b0, bus0.master_address}, 0);
      check("rst_writedata",  bus0.master_writedata, 0);
      check("rst_busy",       busy0, 0);
      check("rst_cmds_done",  {16'b0, done0}, 0);
      check("rst_read_poll",  bus1.master_read, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Basic command, new texture; tex to plot spans three dead-cycle gaps.
      push_cmd(0, 7'h05, 9'd159, 8'd119, 1'b0);
      wait_idle(0, "cmdA_idle");
      check("cmdA_done", {16'b0, done0}, 1);
      check("cmdA_spacing", t_plot0 - t_tex0, 6);
      check("cmdA_queue_empty", q0.size(), 0);

      // Fill command skips the coordinate writes.
      push_cmd(0, 7'h6A, 9'd300, 8'd200, 1'b1);
      wait_idle(0, "fill_idle");
      check("fill_done", {16'b0, done0}, 2);
      check("fill_queue_empty", q0.size(), 0);

      // Same texture twice: the second command issues no texture write.
      push_cmd(0, 7'h01, 9'd10, 8'd119, 1'b0);
      push_cmd(0, 7'h01, 9'd19, 8'd13, 1'b0);
      wait_idle(0, "pair_idle");
      check("pair_done", {16'b0, done0}, 4);
      check("pair_queue_empty", q0.size(), 0);

      // Stall the x write for five cycles; the request must hold steady.
      push_cmd(0, 7'h05, 9'd159, 8'd119, 1'b0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(bus0.master_write && bus0.master_address == 4'd1) && n < 100);
      bus0.master_waitrequest = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("stall_write", bus0.master_write, 1);
         check("stall_addr", {28'b0, bus0.master_address}, 1);
         check("stall_data", bus0.master_writedata, 159);
         @(negedge clk);
      end
      check("stall_still_write", bus0.master_write, 1);
      bus0.master_waitrequest = 1'b0;
      wait_idle(0, "stall_idle");
      check("stall_done", {16'b0, done0}, 5);
      check("stall_queue_empty", q0.size(), 0);

      // Polling instance: three busy replies then idle.
      push_cmd(1, 7'h33, 9'd7, 8'd8, 1'b0);
      wait_idle(1, "poll_idle");
      check("poll_reads", poll_cnt, 4);
      check("poll_done", {16'b0, done1}, 1);
      check("poll_queue_empty", q1.size(), 0);

      // Fill FIFO behind a stalled transfer, then reset mid-stream.
      bus0.master_waitrequest = 1'b1;
      for (int i = 0; i < 5; i++) push_cmd(0, 7'h10 + 7'(i), 9'(i), 8'(i), 1'b0);
      check("full_cmd_ready", bus0.cmd_ready, 0);
      check("full_busy", busy0, 1);
      check("full_write_pending", bus0.master_write, 1);
      @(negedge clk);
      #2;
      rst = 1'b1;
      q0.delete();
      q1.delete();
      m_tex_valid[0] = 1'b0;
      m_tex_valid[1] = 1'b0;
      #1;
      check("arst_cmd_ready", bus0.cmd_ready, 1);
      check("arst_write", bus0.master_write, 0);
      check("arst_address", {28'b0, bus0.master_address}, 0);
      check("arst_writedata", bus0.master_writedata, 0);
      check("arst_busy", busy0, 0);
      check("arst_cmds_done", {16'b0, done0}, 0);
      bus0.master_waitrequest = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // After reset the texture cache is invalid, so texture 0x05 is rewritten.
      push_cmd(0, 7'h05, 9'd1, 8'd2, 1'b0);
      wait_idle(0, "recover_idle");
      check("recover_done", {16'b0, done0}, 1);
      check("recover_queue_empty", q0.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
